// File: rtl/nearest_pkg.sv
// Shared types and helpers for the nearest-sample stream search.
//   state_t  : search FSM states (IDLE, RUN, DONE).
//   abs_diff : unsigned distance |a - b|. It is computed at DIST_W bits, so callers
//              zero-extend their operands and truncate the result back to their width.
//              Because the operands are zero-extended, the distance never wraps
//              (0x00 vs 0xFF is 0xFF).
package nearest_pkg;

  localparam int unsigned DIST_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [DIST_W-1:0] abs_diff(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/nearest_of_two.sv
// Combinational two-input nearest comparator.
// It chooses between the running best and a new candidate, judged by distance to refVal.
//   curBest, curDist : running best sample and its distance
//   candidate        : new sample
//   refVal           : reference value
//   firstFlag        : candidate is the first sample of the search and is loaded unconditionally
//   newBest, newDist : updated best and distance
// The candidate replaces the best only when it is strictly nearer, so on a tie the earlier sample wins.
module nearest_of_two
  import nearest_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] curBest,
  input  logic [WIDTH-1:0] curDist,
  input  logic [WIDTH-1:0] candidate,
  input  logic [WIDTH-1:0] refVal,
  input  logic             firstFlag,
  output logic [WIDTH-1:0] newBest,
  output logic [WIDTH-1:0] newDist
);

  logic [WIDTH-1:0] cand_dist;

  always_comb begin
    cand_dist = WIDTH'(abs_diff(DIST_W'(candidate), DIST_W'(refVal)));
    newBest   = curBest;
    newDist   = curDist;
    if (firstFlag || (cand_dist < curDist)) begin
      newBest = candidate;
      newDist = cand_dist;
    end
  end

endmodule

// File: rtl/nearest_stream_search.sv
// Streams up to MAX_LEN samples and returns the one nearest to a latched reference.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, refI         : begin a search (accepted only in IDLE) and latch the reference
//   inData, inValid,
//   inLast, inReady     : sample stream. inLast is qualified by inValid.
//   result, resDist,
//   sampleCount         : nearest sample, its distance, and the number of samples consumed
//   resValid, resReady  : result handshake. The outputs are held while resValid && !resReady.
//   busy                : state is not IDLE
// The block accepts one sample per cycle with no bubbles. resValid rises in the cycle after the
// final sample is accepted.
module nearest_stream_search
  import nearest_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] refI,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  input  logic             inLast,
  output logic             inReady,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resDist,
  output logic [CNT_W-1:0] sampleCount,
  output logic             resValid,
  input  logic             resReady,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] new_best;
  logic [WIDTH-1:0] new_dist;
  logic [CNT_W-1:0] count_inc;
  logic             first_sample;

  // result/resDist double as the running best and its distance.
  // A count of zero marks the first sample of the search.
  assign first_sample = (sampleCount == '0);
  assign count_inc    = sampleCount + CNT_W'(1);

  nearest_of_two #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .curBest  (result),
    .curDist  (resDist),
    .candidate(inData),
    .refVal   (ref_q),
    .firstFlag(first_sample),
    .newBest  (new_best),
    .newDist  (new_dist)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ref_q       <= '0;
      result      <= '0;
      resDist     <= '0;
      sampleCount <= '0;
      inReady     <= 1'b0;
      resValid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            ref_q       <= refI;
            sampleCount <= '0;
            inReady     <= 1'b1;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          // inReady is always high in RUN, so inValid alone qualifies an accept.
          if (inValid) begin
            result      <= new_best;
            resDist     <= new_dist;
            sampleCount <= count_inc;
            if (inLast || (count_inc == CNT_W'(MAX_LEN))) begin
              state    <= DONE;
              inReady  <= 1'b0;
              resValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (resReady) begin
            state    <= IDLE;
            resValid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          inReady  <= 1'b0;
          resValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nearest_stream_search.sv
module tb_nearest_stream_search;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  refI;
  logic [W-1:0]  inData;
  logic          inValid;
  logic          inLast;
  logic          inReady;
  logic [W-1:0]  result;
  logic [W-1:0]  resDist;
  logic [CW-1:0] sampleCount;
  logic          resValid;
  logic          resReady;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] smp [8];

  always #5 clk = ~clk;

  nearest_stream_search #(
    .WIDTH  (W),
    .MAX_LEN(ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .refI       (refI),
    .inData     (inData),
    .inValid    (inValid),
    .inLast     (inLast),
    .inReady    (inReady),
    .result     (result),
    .resDist    (resDist),
    .sampleCount(sampleCount),
    .resValid   (resValid),
    .resReady   (resReady),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // The search keeps the first sample with the smallest |sample - ref| and ends at the
  // sample flagged last or at the ML-th sample, whichever comes first.
  function automatic void model(input logic [7:0] r, input int n, input int last_idx,
                                output logic [7:0] best, output logic [7:0] bd, output int cnt);
    int d;
    int dbest;
    cnt   = 0;
    best  = 8'h00;
    dbest = 0;
    for (int i = 0; i < n; i++) begin
      d = int'(smp[i]) - int'(r);
      if (d < 0) d = -d;
      if (i == 0 || d < dbest) begin
        best  = smp[i];
        dbest = d;
      end
      cnt++;
      if (i == last_idx || cnt == ML) break;
    end
    bd = 8'(dbest);
  endfunction

  task automatic run_search(input logic [7:0] r, input int n, input int last_idx,
                            input bit gaps);
    logic [7:0] eb;
    logic [7:0] ed;
    int         ec;
    model(r, n, last_idx, eb, ed, ec);
    @(negedge clk);
    start = 1'b1;
    refI  = r;
    @(negedge clk);
    start = 1'b0;
    refI  = 8'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < ec; i++) begin
      if (gaps) begin
        // Idle cycles carry junk data, stray inLast and start pulses, none of which may count.
        repeat ($urandom_range(0, 2)) begin
          inValid = 1'b0;
          inData  = 8'($urandom);
          inLast  = 1'($urandom);
          start   = 1'($urandom);
          @(negedge clk);
        end
        start = 1'b0;
      end
      check("in_ready_run", 32'(inReady), 32'd1);
      check("no_early_valid", 32'(resValid), 32'd0);
      inValid = 1'b1;
      inData  = smp[i];
      inLast  = (i == last_idx);
      @(negedge clk);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    check("res_valid", 32'(resValid), 32'd1);
    check("result", 32'(result), 32'(eb));
    check("res_dist", 32'(resDist), 32'(ed));
    check("sample_count", 32'(sampleCount), 32'(ec));
    check("in_ready_done", 32'(inReady), 32'd0);
  endtask

  task automatic ack(input int delay);
    repeat (delay) begin
      @(negedge clk);
      check("hold_valid", 32'(resValid), 32'd1);
    end
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    check("idle_valid", 32'(resValid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(inReady), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int li;
    rst_n    = 1'b0;
    start    = 1'b0;
    refI     = '0;
    inData   = '0;
    inValid  = 1'b0;
    inLast   = 1'b0;
    resReady = 1'b0;
    #12;
    check("rst_result", 32'(result), 32'd0);
    check("rst_dist", 32'(resDist), 32'd0);
    check("rst_count", 32'(sampleCount), 32'd0);
    check("rst_valid", 32'(resValid), 32'd0);
    check("rst_ready", 32'(inReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic search with back-to-back samples.
    smp[0] = 8'h2E; smp[1] = 8'h0E; smp[2] = 8'h1F;
    run_search(8'h0F, 3, 2, 1'b0);
    check("t1_result", 32'(result), 32'h0E);
    check("t1_dist", 32'(resDist), 32'h01);
    check("t1_count", 32'(sampleCount), 32'd3);
    ack(0);

    // On a tie, the earlier sample must be kept.
    smp[0] = 8'h0E; smp[1] = 8'h12;
    run_search(8'h10, 2, 1, 1'b0);
    check("tie_result", 32'(result), 32'h0E);
    check("tie_dist", 32'(resDist), 32'h02);
    ack(1);

    // The distance must not wrap.
    smp[0] = 8'h00; smp[1] = 8'hF0;
    run_search(8'hFF, 2, 1, 1'b0);
    check("nowrap_result", 32'(result), 32'hF0);
    check("nowrap_dist", 32'(resDist), 32'h0F);
    ack(0);

    // The search ends at the MAX_LEN-th sample without inLast. Backpressure and start are checked in DONE.
    smp[0] = 8'h80; smp[1] = 8'h40; smp[2] = 8'h20; smp[3] = 8'h11;
    run_search(8'h10, 4, -1, 1'b0);
    check("max_count", 32'(sampleCount), 32'd4);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      refI  = 8'hAA;
      @(negedge clk);
      check("bp_valid", 32'(resValid), 32'd1);
      check("bp_result", 32'(result), 32'h11);
      check("bp_dist", 32'(resDist), 32'h01);
      check("bp_count", 32'(sampleCount), 32'd4);
      check("bp_ready", 32'(inReady), 32'd0);
    end
    start = 1'b0;
    ack(0);

    // Reset asserted mid-search after 2 samples.
    @(negedge clk);
    start = 1'b1;
    refI  = 8'h33;
    @(negedge clk);
    start   = 1'b0;
    inValid = 1'b1;
    inData  = 8'h01;
    @(negedge clk);
    inData = 8'h02;
    @(negedge clk);
    inValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_dist", 32'(resDist), 32'd0);
    check("mid_rst_count", 32'(sampleCount), 32'd0);
    check("mid_rst_valid", 32'(resValid), 32'd0);
    check("mid_rst_ready", 32'(inReady), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    smp[0] = 8'h05;
    run_search(8'h00, 1, 0, 1'b0);
    check("post_rst_result", 32'(result), 32'h05);
    check("post_rst_count", 32'(sampleCount), 32'd1);
    ack(0);

    // Randomized searches with gaps, stray inLast/start, and random result delays.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) smp[i] = 8'($urandom);
      if (t % 5 == 0) begin
        // Pack samples near the reference to provoke ties.
        for (int i = 0; i < 8; i++) smp[i] = 8'h40 + 8'($urandom_range(0, 4)) - 8'd2;
      end
      if (n >= ML && $urandom_range(0, 1) == 1) li = -1;
      else li = $urandom_range(0, n - 1);
      run_search((t % 5 == 0) ? 8'h40 : 8'($urandom), n, li, 1'b1);
      ack($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nearest_stream_search.md
Name: nearest_stream_search

Overview:
- Sequential front-end that streams up to MAX_LEN candidate samples and returns the single sample closest to a latched reference value.
- Reduces the stream pairwise: the running best is compared against each new sample by a combinational two-input nearest comparator.
- Sits directly upstream of the existing two-input distance comparator style logic and extends it from a fixed pair to an arbitrary-length stream.
- The result is presented with a valid/ready handshake to downstream logic.

Parameters:
- WIDTH, 8, bit width of samples, reference and result.
- MAX_LEN, 16, maximum samples per search; a search is forced to end at this count.
- CNT_W, $clog2(MAX_LEN+1), width of the sample counter and of sampleCount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a search; accepted only in IDLE.
- refI  input  WIDTH  reference value, latched on an accepted start.
- inData  input  WIDTH  candidate sample.
- inValid  input  1  inData is valid.
- inLast  input  1  marks the final sample of the search; qualified by inValid.
- inReady  output  1  block accepts a sample this cycle.
- result  output  WIDTH  nearest sample found.
- resDist  output  WIDTH  |result - ref| of the nearest sample.
- sampleCount  output  CNT_W  number of samples consumed in the search.
- resValid  output  1  result, resDist and sampleCount are valid.
- resReady  input  1  downstream accepts the result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - result, resDist, sampleCount, the ref register and the count all clear to 0.
  - resValid=0, inReady=0, busy=0.
- Reset asserted mid-search aborts the search immediately; no partial result is emitted.
- FSM states: IDLE, RUN, DONE.
  - IDLE: inReady=0. start=1 latches refI, clears count, and moves to RUN on the next edge.
  - RUN: inReady=1. A sample is accepted when inValid && inReady.
    - The first accepted sample loads best unconditionally.
    - Each later sample replaces best only if its distance is strictly less than bestDist.
    - On a tie, the earlier sample is kept.
    - The count increments on every accepted sample.
    - The search moves to DONE after an accepted sample with inLast=1, or when the accepted sample makes count==MAX_LEN.
  - DONE: inReady=0, resValid=1, and all outputs are held stable. resValid && resReady returns to IDLE on the next edge.
- start is ignored in RUN and DONE.
- Latency: resValid rises in the cycle after the edge on which the final sample is accepted.
- Throughput: one sample per cycle. There is no handshake bubble between samples.
- Distance: computed in WIDTH+1 bits as a-b, then negated if negative, truncated to WIDTH bits. No modular wrap: 0x00 vs ref 0xFF gives distance 0xFF.
- inLast without inValid has no effect.
- A search cannot have zero samples.
- Output timing: result, resDist and sampleCount update registered. They may change during RUN but are only meaningful when resValid=1.

Decomposition:
- Shared package nearest_pkg holds:
  - the state_t enum {IDLE, RUN, DONE};
  - the function abs_diff(a, b) returning the WIDTH-bit distance.
- Sub-module nearest_of_two: combinational comparator.
  - Inputs: curBest, curDist, candidate, ref, firstFlag.
  - Outputs: newBest, newDist, using the strict-less / keep-earlier tie rule.
  - Instantiated once in the main block.

Test Plan:
- ref=0x0F; stream 0x2E, 0x0E, 0x1F(last), back-to-back -> result=0x0E, resDist=0x01, sampleCount=3, resValid one cycle after the last accept.
- Tie: ref=0x10; stream 0x0E, 0x12(last) -> result=0x0E, resDist=0x02.
- No wrap: ref=0xFF; stream 0x00, 0xF0(last) -> result=0xF0, resDist=0x0F.
- MAX_LEN=4; stream 0x80, 0x40, 0x20, 0x11 with inLast never set, ref=0x10 -> DONE after the 4th sample, result=0x11, resDist=0x01, count=4, inReady=0 afterwards.
- Backpressure:
  - hold resReady=0 for 5 cycles in DONE -> resValid and outputs stable, and a start pulse during DONE is ignored;
  - resReady=1 -> IDLE next cycle, busy=0.
- Reset mid-RUN after 2 samples -> all outputs 0 immediately.
  - A new search with ref=0x00, stream 0x05(last) then gives result=0x05, count=1.
